// File: rtl/npu_os_sequencer_pkg.sv
// Shared types and constants for the output-stationary NPU sequencer.
// Optional cycle counter at offset 0x30 is built only with NPU_SEQ_PERF_EN.
package pkg_npu_seq;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FLOW1    = 3'd1,
        ST_FLOW2    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_STORE    = 3'd4,
        ST_TILE_END = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_A_BASE   = 8'h08;
    localparam logic [7:0] OFF_M        = 8'h0C;
    localparam logic [7:0] OFF_W_BASE   = 8'h10;
    localparam logic [7:0] OFF_N        = 8'h14;
    localparam logic [7:0] OFF_O_BASE   = 8'h18;
    localparam logic [7:0] OFF_K        = 8'h1C;
    localparam logic [7:0] OFF_TILES    = 8'h20;
    localparam logic [7:0] OFF_A_STRIDE = 8'h24;
    localparam logic [7:0] OFF_W_STRIDE = 8'h28;
    localparam logic [7:0] OFF_O_STRIDE = 8'h2C;
    localparam logic [7:0] OFF_PERF     = 8'h30;

    localparam logic [2:0] SA_OP_IDLE  = 3'b000;
    localparam logic [2:0] SA_OP_FLOW  = 3'b100;
    localparam logic [2:0] SA_OP_SHIFT = 3'b110;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

endpackage

// File: rtl/npu_seq_regfile.sv
// Memory-mapped parameter/status registers for the NPU sequencer.
// With NPU_SEQ_PERF_EN defined, a 32-bit busy-cycle counter is readable at 0x30.
module npu_seq_regfile
    import pkg_npu_seq::*;
#(
    parameter int                    DWidth     = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    RW         = 5,
    parameter int                    CW         = 5,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] PARA_BASE  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cen,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DWidth-1:0]     i_wdata,
    input  logic                  i_busy,
    input  logic                  i_start_accept,
    input  logic                  i_start_reject,
    input  logic                  i_done_set,
    output logic [DWidth-1:0]     o_rdata,
    output logic                  o_start_req,
    output logic                  o_irq_en,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_a_base,
    output logic [RW-1:0]         o_m,
    output logic [ADDR_WIDTH-1:0] o_w_base,
    output logic [CW-1:0]         o_n,
    output logic [ADDR_WIDTH-1:0] o_o_base,
    output logic [CNT_WIDTH-1:0]  o_k,
    output logic [CNT_WIDTH-1:0]  o_tiles,
    output logic [ADDR_WIDTH-1:0] o_a_stride,
    output logic [ADDR_WIDTH-1:0] o_w_stride,
    output logic [ADDR_WIDTH-1:0] o_o_stride
);

    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_hit;
    logic [7:0]            w_sel;
    logic                  w_wr;
    logic [DWidth-1:0]     w_rd_val;

    logic [DWidth-1:0]     r_rdata;
    logic                  r_irq_en;
    logic                  r_done;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_a_base, r_w_base, r_o_base;
    logic [ADDR_WIDTH-1:0] r_a_stride, r_w_stride, r_o_stride;
    logic [RW-1:0]         r_m;
    logic [CW-1:0]         r_n;
    logic [CNT_WIDTH-1:0]  r_k, r_tiles;

    // Decode relative to PARA_BASE; anything beyond the first 256 bytes is unmapped.
    assign w_off = i_addr - PARA_BASE;
    assign w_hit = (w_off[ADDR_WIDTH-1:8] == '0);
    assign w_sel = w_off[7:0];
    assign w_wr  = i_cen & i_wen & w_hit;

    assign o_start_req = w_wr && (w_sel == OFF_CTRL) && i_wdata[CTRL_START_BIT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_base   <= '0;
            r_w_base   <= '0;
            r_o_base   <= '0;
            r_a_stride <= '0;
            r_w_stride <= '0;
            r_o_stride <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_tiles    <= '0;
        end else if (w_wr && !i_busy) begin
            case (w_sel)
                OFF_A_BASE:   r_a_base   <= ADDR_WIDTH'(i_wdata);
                OFF_M:        r_m        <= RW'(i_wdata);
                OFF_W_BASE:   r_w_base   <= ADDR_WIDTH'(i_wdata);
                OFF_N:        r_n        <= CW'(i_wdata);
                OFF_O_BASE:   r_o_base   <= ADDR_WIDTH'(i_wdata);
                OFF_K:        r_k        <= CNT_WIDTH'(i_wdata);
                OFF_TILES:    r_tiles    <= CNT_WIDTH'(i_wdata);
                OFF_A_STRIDE: r_a_stride <= ADDR_WIDTH'(i_wdata);
                OFF_W_STRIDE: r_w_stride <= ADDR_WIDTH'(i_wdata);
                OFF_O_STRIDE: r_o_stride <= ADDR_WIDTH'(i_wdata);
                default: ;
            endcase
        end
    end

    // Hardware set wins over a simultaneous software W1C.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr && (w_sel == OFF_CTRL))
                r_irq_en <= i_wdata[CTRL_IRQ_EN_BIT];

            if (i_start_accept)
                r_done <= 1'b0;
            else if (i_done_set)
                r_done <= 1'b1;
            else if (w_wr && (w_sel == OFF_STATUS) && i_wdata[STATUS_DONE_BIT])
                r_done <= 1'b0;

            if (i_start_reject)
                r_err <= 1'b1;
            else if (w_wr && (w_sel == OFF_STATUS) && i_wdata[STATUS_ERR_BIT])
                r_err <= 1'b0;
        end
    end

`ifdef NPU_SEQ_PERF_EN
    logic [31:0] r_perf_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_perf_cnt <= '0;
        else if (i_start_accept)
            r_perf_cnt <= '0;
        else if (i_busy)
            r_perf_cnt <= r_perf_cnt + 32'd1;
    end
`endif

    always_comb begin
        w_rd_val = '0;
        if (w_hit) begin
            case (w_sel)
                OFF_CTRL:     w_rd_val[CTRL_IRQ_EN_BIT] = r_irq_en;
                OFF_STATUS: begin
                    w_rd_val[STATUS_DONE_BIT] = r_done;
                    w_rd_val[STATUS_BUSY_BIT] = i_busy;
                    w_rd_val[STATUS_ERR_BIT]  = r_err;
                end
                OFF_A_BASE:   w_rd_val = DWidth'(r_a_base);
                OFF_M:        w_rd_val = DWidth'(r_m);
                OFF_W_BASE:   w_rd_val = DWidth'(r_w_base);
                OFF_N:        w_rd_val = DWidth'(r_n);
                OFF_O_BASE:   w_rd_val = DWidth'(r_o_base);
                OFF_K:        w_rd_val = DWidth'(r_k);
                OFF_TILES:    w_rd_val = DWidth'(r_tiles);
                OFF_A_STRIDE: w_rd_val = DWidth'(r_a_stride);
                OFF_W_STRIDE: w_rd_val = DWidth'(r_w_stride);
                OFF_O_STRIDE: w_rd_val = DWidth'(r_o_stride);
`ifdef NPU_SEQ_PERF_EN
                OFF_PERF:     w_rd_val = DWidth'(r_perf_cnt);
`endif
                default:      w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_rdata <= '0;
        else if (i_cen && !i_wen)
            r_rdata <= w_rd_val;
    end

    assign o_rdata    = r_rdata;
    assign o_irq_en   = r_irq_en;
    assign o_done     = r_done;
    assign o_a_base   = r_a_base;
    assign o_m        = r_m;
    assign o_w_base   = r_w_base;
    assign o_n        = r_n;
    assign o_o_base   = r_o_base;
    assign o_k        = r_k;
    assign o_tiles    = r_tiles;
    assign o_a_stride = r_a_stride;
    assign o_w_stride = r_w_stride;
    assign o_o_stride = r_o_stride;

endmodule

// File: rtl/npu_os_sequencer.sv
// Output-stationary systolic flow sequencer with multi-tile base-address stepping.
// Define NPU_SEQ_PERF_EN to add the busy-cycle counter in the register file.
module npu_os_sequencer
    import pkg_npu_seq::*;
#(
    parameter int                    DWidth     = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ARRAY_N    = 16,
    parameter int                    ARRAY_M    = 16,
    parameter logic [ADDR_WIDTH-1:0] PARA_BASE  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cen_i,
    input  logic                       wen_i,
    input  logic [ADDR_WIDTH-1:0]      addr_i,
    input  logic [DWidth-1:0]          wdata_i,
    output logic [DWidth-1:0]          rdata_o,
    output logic                       a_buf_on_o,
    output logic                       w_buf_on_o,
    output logic [ADDR_WIDTH-1:0]      a_base_addr_o,
    output logic [ADDR_WIDTH-1:0]      w_base_addr_o,
    output logic [ADDR_WIDTH-1:0]      o_base_addr_o,
    output logic [$clog2(ARRAY_N):0]   num_rows_o,
    output logic [$clog2(ARRAY_M):0]   num_cols_o,
    output logic [2:0]                 sa_op_o,
    output logic                       sa_reset_o,
    output logic                       o_ag_on_o,
    output logic                       irq_o
);

    localparam int RW = $clog2(ARRAY_N) + 1;
    localparam int CW = $clog2(ARRAY_M) + 1;

    state_t                r_state, w_next;
    logic [CNT_WIDTH-1:0]  r_phase;
    logic [CNT_WIDTH-1:0]  r_tile_cnt;
    logic [ADDR_WIDTH-1:0] r_a_work, r_w_work, r_o_work;

    logic                  w_busy, w_start_req, w_cfg_ok;
    logic                  w_start_accept, w_start_reject, w_phase_last;
    logic                  w_irq_en, w_done;
    logic [ADDR_WIDTH-1:0] w_a_base, w_w_base, w_o_base;
    logic [ADDR_WIDTH-1:0] w_a_stride, w_w_stride, w_o_stride;
    logic [RW-1:0]         w_m;
    logic [CW-1:0]         w_n;
    logic [CNT_WIDTH-1:0]  w_k, w_tiles, w_m_c, w_n_c;

    assign w_busy = (r_state != ST_IDLE);
    assign w_m_c  = CNT_WIDTH'(w_m);
    assign w_n_c  = CNT_WIDTH'(w_n);

    assign w_cfg_ok = (w_m != '0) && (w_m <= RW'(ARRAY_N)) &&
                      (w_n != '0) && (w_n <= CW'(ARRAY_M)) &&
                      (w_k != '0) && (w_tiles != '0);

    // Starts arriving outside IDLE are dropped without touching err.
    assign w_start_accept = w_start_req && !w_busy && w_cfg_ok;
    assign w_start_reject = w_start_req && !w_busy && !w_cfg_ok;

    npu_seq_regfile #(
        .DWidth     (DWidth),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RW         (RW),
        .CW         (CW),
        .CNT_WIDTH  (CNT_WIDTH),
        .PARA_BASE  (PARA_BASE)
    ) u_regfile (
        .i_clk          (clk_i),
        .i_rst_n        (rst_ni),
        .i_cen          (cen_i),
        .i_wen          (wen_i),
        .i_addr         (addr_i),
        .i_wdata        (wdata_i),
        .i_busy         (w_busy),
        .i_start_accept (w_start_accept),
        .i_start_reject (w_start_reject),
        .i_done_set     (r_state == ST_DONE),
        .o_rdata        (rdata_o),
        .o_start_req    (w_start_req),
        .o_irq_en       (w_irq_en),
        .o_done         (w_done),
        .o_a_base       (w_a_base),
        .o_m            (w_m),
        .o_w_base       (w_w_base),
        .o_n            (w_n),
        .o_o_base       (w_o_base),
        .o_k            (w_k),
        .o_tiles        (w_tiles),
        .o_a_stride     (w_a_stride),
        .o_w_stride     (w_w_stride),
        .o_o_stride     (w_o_stride)
    );

    // Last cycle of each timed phase: FLOW1 K, FLOW2 M+N-1, DRAIN ARRAY_N-M, STORE M+1.
    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            ST_FLOW1: w_phase_last = (r_phase == w_k - CNT_WIDTH'(1));
            ST_FLOW2: w_phase_last = (r_phase == w_m_c + w_n_c - CNT_WIDTH'(2));
            ST_DRAIN: w_phase_last = (r_phase == CNT_WIDTH'(ARRAY_N) - w_m_c - CNT_WIDTH'(1));
            ST_STORE: w_phase_last = (r_phase == w_m_c);
            default:  w_phase_last = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        a_buf_on_o = 1'b0;
        w_buf_on_o = 1'b0;
        sa_op_o    = SA_OP_IDLE;
        sa_reset_o = 1'b0;
        o_ag_on_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                sa_reset_o = 1'b1;
                if (w_start_accept)
                    w_next = ST_FLOW1;
            end
            ST_FLOW1: begin
                a_buf_on_o = 1'b1;
                w_buf_on_o = 1'b1;
                sa_op_o    = SA_OP_FLOW;
                if (w_phase_last)
                    w_next = ST_FLOW2;
            end
            ST_FLOW2: begin
                sa_op_o = SA_OP_FLOW;
                if (w_phase_last)
                    w_next = (w_m == RW'(ARRAY_N)) ? ST_STORE : ST_DRAIN;
            end
            ST_DRAIN: begin
                sa_op_o = SA_OP_SHIFT;
                if (w_phase_last)
                    w_next = ST_STORE;
            end
            ST_STORE: begin
                sa_op_o   = SA_OP_SHIFT;
                o_ag_on_o = 1'b1;
                if (w_phase_last)
                    w_next = ST_TILE_END;
            end
            ST_TILE_END: begin
                sa_reset_o = 1'b1;
                w_next     = (r_tile_cnt == w_tiles - CNT_WIDTH'(1)) ? ST_DONE : ST_FLOW1;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_next;
            r_phase <= (w_next != r_state) ? '0 : r_phase + CNT_WIDTH'(1);
        end
    end

    // Working bases wrap modulo 2^ADDR_WIDTH when stepped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tile_cnt <= '0;
            r_a_work   <= '0;
            r_w_work   <= '0;
            r_o_work   <= '0;
        end else if (w_start_accept) begin
            r_tile_cnt <= '0;
            r_a_work   <= w_a_base;
            r_w_work   <= w_w_base;
            r_o_work   <= w_o_base;
        end else if (r_state == ST_TILE_END) begin
            r_tile_cnt <= r_tile_cnt + CNT_WIDTH'(1);
            r_a_work   <= r_a_work + w_a_stride;
            r_w_work   <= r_w_work + w_w_stride;
            r_o_work   <= r_o_work + w_o_stride;
        end
    end

    assign a_base_addr_o = w_busy ? r_a_work : w_a_base;
    assign w_base_addr_o = w_busy ? r_w_work : w_w_base;
    assign o_base_addr_o = w_busy ? r_o_work : w_o_base;
    assign num_rows_o    = w_m;
    assign num_cols_o    = w_n;
    assign irq_o         = w_done & w_irq_en;

endmodule

// File: tb/tb_npu_os_sequencer.sv
// Directed bench for npu_os_sequencer: bus reads and per-run phase tallies are
// scored against an expected queue filled from the programmed configuration.
module tb_npu_os_sequencer;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_STATUS   = 32'h04;
    localparam logic [31:0] A_A_BASE   = 32'h08;
    localparam logic [31:0] A_M        = 32'h0C;
    localparam logic [31:0] A_W_BASE   = 32'h10;
    localparam logic [31:0] A_N        = 32'h14;
    localparam logic [31:0] A_O_BASE   = 32'h18;
    localparam logic [31:0] A_K        = 32'h1C;
    localparam logic [31:0] A_TILES    = 32'h20;
    localparam logic [31:0] A_A_STRIDE = 32'h24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        a_buf_on, w_buf_on, o_ag_on, sa_reset, irq;
    logic [31:0] a_base_addr, w_base_addr, o_base_addr;
    logic [4:0]  num_rows, num_cols;
    logic [2:0]  sa_op;

    logic [31:0] exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned cnt_abuf, cnt_flow, cnt_drain, cnt_store, cnt_rst, run_len;

    npu_os_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cen_i         (cen),
        .wen_i         (wen),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .rdata_o       (rdata),
        .a_buf_on_o    (a_buf_on),
        .w_buf_on_o    (w_buf_on),
        .a_base_addr_o (a_base_addr),
        .w_base_addr_o (w_base_addr),
        .o_base_addr_o (o_base_addr),
        .num_rows_o    (num_rows),
        .num_cols_o    (num_cols),
        .sa_op_o       (sa_op),
        .sa_reset_o    (sa_reset),
        .o_ag_on_o     (o_ag_on),
        .irq_o         (irq)
    );

    // Clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=<empty queue>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        exp_q.push_back(exp);
        check(tag, obs);
    endtask

    // Drivers
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        cen = 1'b1; wen = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        cen = 1'b0; wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        cen = 1'b1; wen = 1'b0; addr = a;
        @(negedge clk);
        cen = 1'b0;
        d = rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        exp_q.push_back(exp);
        bus_read(a, d);
        check(tag, d);
    endtask

    // Called at the negedge right after the start edge; stops when irq rises.
    task automatic run_and_tally(input bit capture_abase);
        int unsigned t0;
        logic prev_abuf;
        cnt_abuf = 0; cnt_flow = 0; cnt_drain = 0; cnt_store = 0; cnt_rst = 0;
        t0 = cyc;
        prev_abuf = 1'b0;
        while (!irq && (cyc - t0) < 1000) begin
            if (a_buf_on) cnt_abuf++;
            if (sa_op == 3'b100) cnt_flow++;
            if (sa_op == 3'b110 && !o_ag_on) cnt_drain++;
            if (o_ag_on) cnt_store++;
            if (sa_reset) cnt_rst++;
            if (capture_abase && a_buf_on && !prev_abuf) check("a_base_tile", a_base_addr);
            prev_abuf = a_buf_on;
            @(negedge clk);
        end
        run_len = cyc - t0;
    endtask

    initial begin : stimulus
        logic [31:0] d;
        int unsigned t0;

        // Reset
        repeat (3) @(negedge clk);
        expect_now("rst_sa_reset", {31'd0, sa_reset}, 32'h1);
        expect_now("rst_sa_op", {29'd0, sa_op}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_now("rst_rdata", rdata, 32'h0);
        expect_now("rst_outs", {28'd0, a_buf_on, w_buf_on, o_ag_on, irq}, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0);

        // Single tile, full array: FLOW1 8, FLOW2 31, no DRAIN, STORE 17, TILE_END 1, DONE 1
        bus_write(A_CTRL, 32'h2);
        bus_write(A_M, 32'd16);
        bus_write(A_N, 32'd16);
        bus_write(A_K, 32'd8);
        bus_write(A_TILES, 32'd1);
        expect_now("num_rows", {27'd0, num_rows}, 32'd16);
        exp_q.push_back(32'd8);
        exp_q.push_back(32'd39);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd17);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd58);
        bus_write(A_CTRL, 32'h3);
        run_and_tally(1'b0);
        check("t1_flow1", cnt_abuf);
        check("t1_flow", cnt_flow);
        check("t1_drain", cnt_drain);
        check("t1_store", cnt_store);
        check("t1_sa_reset", cnt_rst);
        check("t1_len", run_len);
        read_check("t1_status", A_STATUS, 32'h1);
        expect_now("t1_irq_on", {31'd0, irq}, 32'h1);
        bus_write(A_STATUS, 32'h1);
        expect_now("t1_irq_off", {31'd0, irq}, 32'h0);

        // Three tiles, M=4: DRAIN 12 per tile, A base stepping by 0x40
        bus_write(A_M, 32'd4);
        bus_write(A_K, 32'd4);
        bus_write(A_TILES, 32'd3);
        bus_write(A_A_BASE, 32'h100);
        bus_write(A_A_STRIDE, 32'h40);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h140);
        exp_q.push_back(32'h180);
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd69);
        exp_q.push_back(32'd36);
        exp_q.push_back(32'd15);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd124);
        bus_write(A_CTRL, 32'h3);
        run_and_tally(1'b1);
        check("t2_flow1", cnt_abuf);
        check("t2_flow", cnt_flow);
        check("t2_drain", cnt_drain);
        check("t2_store", cnt_store);
        check("t2_sa_reset", cnt_rst);
        check("t2_len", run_len);
        expect_now("t2_idle_abase", a_base_addr, 32'h100);
        bus_write(A_STATUS, 32'h1);

        // Rejected starts: M above array, then K of zero
        bus_write(A_M, 32'd17);
        bus_write(A_CTRL, 32'h3);
        expect_now("err_m_idle", {30'd0, sa_reset, a_buf_on}, 32'h2);
        read_check("err_m_status", A_STATUS, 32'h4);
        bus_write(A_STATUS, 32'h4);
        read_check("err_clr", A_STATUS, 32'h0);
        bus_write(A_M, 32'h24);
        read_check("m_trunc", A_M, 32'h4);
        bus_write(A_K, 32'd0);
        bus_write(A_CTRL, 32'h3);
        expect_now("err_k_idle", {29'd0, sa_op}, 32'h0);
        read_check("err_k_status", A_STATUS, 32'h4);
        bus_write(A_STATUS, 32'h4);
        bus_write(A_K, 32'd4);

        // Writes and a second start while busy are dropped
        bus_write(A_CTRL, 32'h3);
        t0 = cyc;
        bus_write(A_A_BASE, 32'hFFFF);
        read_check("busy_status", A_STATUS, 32'h2);
        bus_write(A_CTRL, 32'h3);
        while (!irq && (cyc - t0) < 1000) @(negedge clk);
        expect_now("busy_len", cyc - t0, 32'd124);
        read_check("busy_abase", A_A_BASE, 32'h100);
        read_check("busy_done", A_STATUS, 32'h1);
        bus_write(A_STATUS, 32'h1);

        // Asynchronous reset in the middle of FLOW2
        bus_write(A_CTRL, 32'h3);
        t0 = cyc;
        while (a_buf_on && (cyc - t0) < 100) @(negedge clk);
        @(negedge clk);
        expect_now("mid_flow2", {28'd0, sa_op, a_buf_on}, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        expect_now("arst_ctl", {27'd0, sa_reset, a_buf_on, w_buf_on, o_ag_on, irq}, 32'h10);
        expect_now("arst_op", {29'd0, sa_op}, 32'h0);
        expect_now("arst_rdata", rdata, 32'h0);
        expect_now("arst_abase", a_base_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("arst_a_base_reg", A_A_BASE, 32'h0);
        read_check("arst_m_reg", A_M, 32'h0);
        read_check("arst_ctrl_reg", A_CTRL, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
